prbs_checker: RTL and testbench

Downstream checker for the 4-bit pseudo-random sequence generator. It consumes the generator's 4-bit word stream (x^4+x^3+1 recurrence, next = {w[2:0], w[3]^w[2]}), self-synchronises to it, and then runs a local reference that advances independently of the input. While locked it compares every received word against that reference, counts word errors and declares loss of lock. Sits between the generator (or the channel under test) and the status/CSR logic.

---
 rtl/prbs_pkg.sv | 19 +
 rtl/prbs_sat_cnt.sv | 39 +++
 rtl/prbs_checker.sv | 163 ++++++++++++++++
 tb/tb_prbs_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the 4-bit PRBS generator and checker.
//   PRBS_W       word width of the x^4+x^3+1 sequence
//   prbs_state_e checker synchronisation states
//   prbs4_next   one-step recurrence, next = {w[2:0], w[3]^w[2]}
package prbs_pkg;

   localparam int PRBS_W = 4;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } prbs_state_e;

   function automatic logic [PRBS_W-1:0] prbs4_next(input logic [PRBS_W-1:0] w);
      return {w[2:0], w[3] ^ w[2]};
   endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// prbs_sat_cnt: saturating up-counter with synchronous clear.
// A clear in the same cycle as an increment yields the increment amount.
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous clear
//   inc         amount to add this cycle (0 = hold)
//   cnt         registered count, saturates at 2^CNT_W-1
module prbs_sat_cnt #(
   parameter int CNT_W = 16,
   parameter int INC_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [INC_W-1:0] inc,
   output logic [CNT_W-1:0] cnt
);

   // One guard bit above the wider operand so the sum never wraps.
   localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [SUM_W-1:0] CNT_MAX_S = SUM_W'(CNT_MAX);

   logic [CNT_W-1:0] cnt_q, cnt_d, base;
   logic [SUM_W-1:0] sum;

   always_comb begin
      base  = clr ? '0 : cnt_q;
      sum   = SUM_W'(base) + SUM_W'(inc);
      cnt_d = (sum > CNT_MAX_S) ? CNT_MAX : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the 4-bit PRBS stream.
// Hunts for a nonzero seed, confirms LOCK_CNT consecutive predicted words,
// then free-runs a local reference and counts mismatching words while locked.
//   clk, rst_n   clock, async active-low reset
//   in_valid     in_data is sampled this cycle
//   in_data      received PRBS word
//   clr_cnt      synchronous clear of the error counters
//   locked       checker is in LOCKED
//   err_pulse    one-cycle strobe per mismatching word while locked
//   err_cnt      saturating count of mismatching words
//   bit_err_cnt  saturating count of mismatching bits (PRBS_CHK_BIT_ERR_EN)
// Optional feature macro: PRBS_CHK_BIT_ERR_EN adds bit_err_cnt.
//
// state  | meaning
// HUNT   | waiting for a valid nonzero word to seed the reference
// SYNC   | reseeding each word, counting consecutive correct predictions
// LOCKED | reference free-runs; mismatches counted, UNLOCK_CNT misses drop lock
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [PRBS_W-1:0] in_data,
   input  logic              clr_cnt,
   output logic              locked,
   output logic              err_pulse,
`ifdef PRBS_CHK_BIT_ERR_EN
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  bit_err_cnt
`else
   output logic [CNT_W-1:0]  err_cnt
`endif
);

   localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_CNT_C = 4'(UNLOCK_CNT);

   prbs_state_e       state_q, state_d;
   logic [PRBS_W-1:0] ref_q, ref_d;
   logic [3:0]        match_cnt_q, match_cnt_d;
   logic [3:0]        miss_cnt_q, miss_cnt_d;
   logic              locked_q, locked_d;
   logic              err_pulse_q, err_pulse_d;

   logic [PRBS_W-1:0] exp_word;
   logic              mismatch;
   logic              err_word;
   logic [3:0]        match_inc;
   logic [3:0]        miss_inc;

   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_word    = 1'b0;
      exp_word    = prbs4_next(ref_q);
      mismatch    = (in_data != exp_word);
      match_inc   = match_cnt_q + 4'd1;
      miss_inc    = miss_cnt_q + 4'd1;

      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (in_data != '0) begin
                  ref_d       = in_data;
                  match_cnt_d = '0;
                  state_d     = SYNC;
               end
            end
            SYNC: begin
               ref_d = in_data;
               if (in_data == '0) begin
                  state_d = HUNT;
               end else if (!mismatch) begin
                  match_cnt_d = match_inc;
                  if (match_inc == LOCK_CNT_C) begin
                     state_d    = LOCKED;
                     miss_cnt_d = '0;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               // Reference advances on its own; the input never reseeds it here.
               ref_d = exp_word;
               if (mismatch) begin
                  err_word   = 1'b1;
                  miss_cnt_d = miss_inc;
                  if (miss_inc == UNLOCK_CNT_C) begin
                     state_d    = HUNT;
                     miss_cnt_d = '0;
                  end
               end else begin
                  miss_cnt_d = '0;
               end
            end
            default: state_d = HUNT;
         endcase
      end

      locked_d    = (state_d == LOCKED);
      err_pulse_d = err_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         ref_q       <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;

   prbs_sat_cnt #(.CNT_W(CNT_W), .INC_W(1)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (err_word),
      .cnt   (err_cnt)
   );

`ifdef PRBS_CHK_BIT_ERR_EN
   logic [PRBS_W-1:0] bit_diff;
   logic [2:0]        bit_inc;

   always_comb begin
      bit_diff = in_data ^ exp_word;
      bit_inc  = '0;
      if (in_valid && (state_q == LOCKED)) begin
         bit_inc = {2'b00, bit_diff[0]} + {2'b00, bit_diff[1]}
                 + {2'b00, bit_diff[2]} + {2'b00, bit_diff[3]};
      end
   end

   prbs_sat_cnt #(.CNT_W(CNT_W), .INC_W(3)) u_bit_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (bit_inc),
      .cnt   (bit_err_cnt)
   );
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed bench for prbs_checker.
// Two instances share the stimulus: dut (CNT_W=16) and dut_s (CNT_W=2) for
// counter saturation. Expected values are hand-derived from the stream table.
module tb_prbs_checker;
   import prbs_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'b0000;
   logic       clr_cnt = 1'b0;

   logic        locked, err_pulse;
   logic [15:0] err_cnt;
   logic        locked_s, err_pulse_s;
   logic [1:0]  err_cnt_s;
`ifdef PRBS_CHK_BIT_ERR_EN
   logic [15:0] bit_err_cnt;
   logic [1:0]  bit_err_cnt_s;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [3:0] seq [15];

   always #5 clk = ~clk;

   prbs_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .clr_cnt     (clr_cnt),
      .locked      (locked),
      .err_pulse   (err_pulse),
`ifdef PRBS_CHK_BIT_ERR_EN
      .err_cnt     (err_cnt),
      .bit_err_cnt (bit_err_cnt)
`else
      .err_cnt     (err_cnt)
`endif
   );

   prbs_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(2)) dut_s (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .clr_cnt     (clr_cnt),
      .locked      (locked_s),
      .err_pulse   (err_pulse_s),
`ifdef PRBS_CHK_BIT_ERR_EN
      .err_cnt     (err_cnt_s),
      .bit_err_cnt (bit_err_cnt_s)
`else
      .err_cnt     (err_cnt_s)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic lk, input logic ep, input int ec);
      chk({tag, "_locked"}, 32'(locked), 32'(lk));
      chk({tag, "_pulse"},  32'(err_pulse), 32'(ep));
      chk({tag, "_cnt"},    32'(err_cnt), 32'(ec));
   endtask

   task automatic chk_bit(input string tag, input int exp);
`ifdef PRBS_CHK_BIT_ERR_EN
      chk({tag, "_bits"}, 32'(bit_err_cnt), 32'(exp));
`else
      if (exp < 0) $display("unused %s", tag);
`endif
   endtask

   // Inputs change 1 time unit after the edge, outputs are sampled there too.
   task automatic drive(input logic v, input logic [3:0] d, input logic c);
      in_valid = v;
      in_data  = d;
      clr_cnt  = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
   endtask

   initial begin
      seq[0]  = 4'b1000; seq[1]  = 4'b0001; seq[2]  = 4'b0010; seq[3]  = 4'b0100;
      seq[4]  = 4'b1001; seq[5]  = 4'b0011; seq[6]  = 4'b0110; seq[7]  = 4'b1101;
      seq[8]  = 4'b1010; seq[9]  = 4'b0101; seq[10] = 4'b1011; seq[11] = 4'b0111;
      seq[12] = 4'b1111; seq[13] = 4'b1110; seq[14] = 4'b1100;

      #2 rst_n = 1'b0;
      #1;
      chk_out("reset", 1'b0, 1'b0, 0);
      chk("reset_cnt_s", 32'(err_cnt_s), 32'd0);
      chk_bit("reset", 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Lock: seed 1000 repeated once, then four predicted words.
      drive(1'b1, seq[0], 1'b0);
      chk_out("seed", 1'b0, 1'b0, 0);
      drive(1'b1, seq[0], 1'b0);
      chk_out("reseed", 1'b0, 1'b0, 0);
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, seq[i], 1'b0);
         chk_out("sync", 1'b0, 1'b0, 0);
      end
      drive(1'b1, seq[4], 1'b0);
      chk_out("lock", 1'b1, 1'b0, 0);

      // Single error: 0111 where 0011 is expected, then the correct stream.
      drive(1'b1, 4'b0111, 1'b0);
      chk_out("single_err", 1'b1, 1'b1, 1);
      chk_bit("single_err", 1);
      for (int i = 6; i <= 8; i++) begin
         drive(1'b1, seq[i], 1'b0);
         chk_out("after_err", 1'b1, 1'b0, 1);
      end

      // Gap: invalid cycles with garbage data change nothing.
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 4'b0000, 1'b0);
         chk_out("gap", 1'b1, 1'b0, 1);
      end
      chk("gap_state", 32'(dut.state_q), 32'(LOCKED));
      chk("gap_ref", 32'(dut.ref_q), 32'(seq[8]));
      drive(1'b1, seq[9], 1'b0);
      chk_out("post_gap", 1'b1, 1'b0, 1);
      drive(1'b1, seq[10], 1'b0);
      chk_out("post_gap2", 1'b1, 1'b0, 1);

      // Clear with no valid word.
      drive(1'b0, 4'b0000, 1'b1);
      chk_out("clr_idle", 1'b1, 1'b0, 0);
      chk_bit("clr_idle", 0);

      // Unlock: three zero words where 0111, 1111, 1110 are expected.
      drive(1'b1, 4'b0000, 1'b0);
      chk_out("miss1", 1'b1, 1'b1, 1);
      chk_bit("miss1", 3);
      drive(1'b1, 4'b0000, 1'b0);
      chk_out("miss2", 1'b1, 1'b1, 2);
      chk_bit("miss2", 7);
      drive(1'b1, 4'b0000, 1'b0);
      chk_out("miss3", 1'b0, 1'b1, 3);
      chk_bit("miss3", 10);
      chk("miss3_cnt_s", 32'(err_cnt_s), 32'd3);

      // Relock needs LOCK_CNT+1 valid words; no errors counted meanwhile.
      drive(1'b1, seq[14], 1'b0);
      chk_out("relock0", 1'b0, 1'b0, 3);
      for (int i = 0; i <= 2; i++) begin
         drive(1'b1, seq[i], 1'b0);
         chk_out("relock", 1'b0, 1'b0, 3);
      end
      drive(1'b1, seq[3], 1'b0);
      chk_out("relocked", 1'b1, 1'b0, 3);

      drive(1'b0, 4'b0000, 1'b1);
      chk_out("clr2", 1'b1, 1'b0, 0);
      chk("clr2_cnt_s", 32'(err_cnt_s), 32'd0);
      chk_bit("clr2", 0);

      // Five errors without three in a row: large counter 5, small saturates at 3.
      drive(1'b1, 4'b0000, 1'b0);
      chk_out("sat1", 1'b1, 1'b1, 1);
      chk("sat1_s", 32'(err_cnt_s), 32'd1);
      drive(1'b1, 4'b0000, 1'b0);
      chk_out("sat2", 1'b1, 1'b1, 2);
      chk("sat2_s", 32'(err_cnt_s), 32'd2);
      drive(1'b1, seq[6], 1'b0);
      chk_out("sat_ok1", 1'b1, 1'b0, 2);
      drive(1'b1, 4'b0000, 1'b0);
      chk_out("sat3", 1'b1, 1'b1, 3);
      chk("sat3_s", 32'(err_cnt_s), 32'd3);
      drive(1'b1, 4'b0000, 1'b0);
      chk_out("sat4", 1'b1, 1'b1, 4);
      chk("sat4_s", 32'(err_cnt_s), 32'd3);
      drive(1'b1, seq[9], 1'b0);
      chk_out("sat_ok2", 1'b1, 1'b0, 4);
      drive(1'b1, 4'b0000, 1'b0);
      chk_out("sat5", 1'b1, 1'b1, 5);
      chk("sat5_s", 32'(err_cnt_s), 32'd3);
      chk_bit("sat5", 12);

      // Clear together with an error: result is the increment.
      drive(1'b1, 4'b0000, 1'b1);
      chk_out("clr_err", 1'b1, 1'b1, 1);
      chk("clr_err_s", 32'(err_cnt_s), 32'd1);
      chk_bit("clr_err", 3);
      drive(1'b0, 4'b0000, 1'b1);
      chk_out("clr3", 1'b1, 1'b0, 0);
      chk("clr3_s", 32'(err_cnt_s), 32'd0);

      drive(1'b1, seq[12], 1'b0);
      chk_out("good12", 1'b1, 1'b0, 0);
      drive(1'b1, 4'b0000, 1'b0);
      chk_out("pre_rst", 1'b1, 1'b1, 1);

      // Asynchronous reset mid-LOCKED, checked before any further edge.
      #2 rst_n = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 1'b0, 0);
      chk("async_rst_state", 32'(dut.state_q), 32'(HUNT));
      chk("async_rst_cnt_s", 32'(err_cnt_s), 32'd0);
      chk_bit("async_rst", 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b1, seq[13], 1'b0);
      chk_out("post_rst", 1'b0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
